// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the bird CPU memory-mapped bus controller.
// Holds the address map, the value returned for unmapped reads, the
// read-region select encoding, the keypad acknowledge FSM states and the
// address decode helper used by the top level.
package mmio_pkg;

  localparam logic [15:0] RAM1_BASE    = 16'h0000;
  localparam logic [15:0] RAM1_END     = 16'hCFFF;
  localparam logic [15:0] KP_DATA_ADDR = 16'hD000;
  localparam logic [15:0] KP_STAT_ADDR = 16'hD001;
  localparam logic [15:0] SEG_ADDR     = 16'hD002;
  localparam logic [15:0] LED_ADDR     = 16'hD003;
  localparam logic [15:0] ERR_ADDR     = 16'hD004;
  localparam logic [15:0] RAM2_BASE    = 16'hF000;
  localparam logic [15:0] RAM2_END     = 16'hFFFF;
  localparam logic [15:0] UNMAPPED_VAL = 16'hF345;

  // Region addressed in a cycle; registered to steer the read-data mux
  // one cycle later. SEL_NONE doubles as "unmapped".
  typedef enum logic [2:0] {
    SEL_RAM  = 3'd0,
    SEL_KPD  = 3'd1,
    SEL_KPS  = 3'd2,
    SEL_SEG  = 3'd3,
    SEL_LED  = 3'd4,
    SEL_ERR  = 3'd5,
    SEL_NONE = 3'd6
  } sel_e;

  typedef enum logic {
    KP_IDLE  = 1'b0,
    KP_ACKED = 1'b1
  } kp_state_e;

  // Inclusive window test written as an offset compare so it stays correct
  // (and free of always-true comparisons) for a window starting at zero.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] last);
    logic [15:0] offset;
    offset = addr - base;
    return offset <= (last - base);
  endfunction

  function automatic sel_e decode_addr(input logic [15:0] addr);
    sel_e sel;
    if (in_window(addr, RAM1_BASE, RAM1_END) ||
        in_window(addr, RAM2_BASE, RAM2_END)) sel = SEL_RAM;
    else if (addr == KP_DATA_ADDR)           sel = SEL_KPD;
    else if (addr == KP_STAT_ADDR)           sel = SEL_KPS;
    else if (addr == SEG_ADDR)               sel = SEL_SEG;
    else if (addr == LED_ADDR)               sel = SEL_LED;
    else if (addr == ERR_ADDR)               sel = SEL_ERR;
    else                                     sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_bus_controller_kp_ack.sv
// kp_ack_fsm: keypad acknowledge one-shot.
// A read of the keypad data register raises o_kp_ack for exactly one cycle;
// the FSM then waits until the CPU addresses something else before it can
// acknowledge again, so a held read consumes a single key.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_kp_data_hit    cpu_addr equals the keypad data register this cycle
//   i_cpu_we         CPU write strobe (writes never acknowledge)
//   o_kp_ack         registered one-cycle key-consume pulse
module kp_ack_fsm
  import mmio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_kp_data_hit,
  input  logic i_cpu_we,
  output logic o_kp_ack
);

  kp_state_e r_state;
  kp_state_e w_state_nxt;
  logic      r_ack;
  logic      w_ack_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= KP_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    case (r_state)
      KP_IDLE: begin
        if (i_kp_data_hit && !i_cpu_we) begin
          w_state_nxt = KP_ACKED;
          w_ack_nxt   = 1'b1;
        end
      end
      KP_ACKED: begin
        if (!i_kp_data_hit) w_state_nxt = KP_IDLE;
      end
      default: w_state_nxt = KP_IDLE;
    endcase
  end

  assign o_kp_ack = r_ack;

endmodule

// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: address decoder and sequencer between the bird CPU bus
// and the memory-mapped resources (two RAM windows, keypad, seven-segment
// register, LED register, bus-error register).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu_addr/wdata/we CPU access, valid in the cycle of the access
//   cpu_rdata         read data, one cycle after the address
//   mem_addr/wdata/we RAM request (mem_we is combinational)
//   mem_rdata         synchronous RAM read data
//   kp_data           keypad key code or status, chosen by kp_sel_status
//   kp_sel_status     1 = keypad drives status, 0 = key data
//   kp_ack            one-cycle key-consume pulse
//   seg_data, leds    output registers
//   bus_err           sticky unmapped/illegal access flag
module mmio_bus_controller
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [3:0]  kp_data,
  output logic        kp_sel_status,
  output logic        kp_ack,
  output logic [15:0] seg_data,
  output logic [7:0]  leds,
  output logic        bus_err
);

  sel_e        w_sel;
  logic        w_kp_hit;
  logic        w_err_set;
  logic        w_err_clr;
  logic [15:0] w_rdata;

  sel_e        r_sel;
  // Low until the first address has been sampled after reset; keeps
  // cpu_rdata at zero rather than showing the unmapped value.
  logic        r_sel_vld;
  logic [3:0]  r_kp_q;
  logic [15:0] r_seg;
  logic [7:0]  r_leds;
  logic        r_bus_err;

  assign w_sel    = decode_addr(cpu_addr);
  assign w_kp_hit = (w_sel == SEL_KPD) || (w_sel == SEL_KPS);

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_we    = cpu_we && (w_sel == SEL_RAM);

  assign kp_sel_status = (cpu_addr == KP_STAT_ADDR);

  // Keypad registers are read-only, so writing them is flagged like an
  // unmapped access. The set and clear sources never coincide because they
  // decode to different addresses.
  assign w_err_set = (w_sel == SEL_NONE) || (cpu_we && w_kp_hit);
  assign w_err_clr = cpu_we && (w_sel == SEL_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= SEL_NONE;
      r_sel_vld <= 1'b0;
      r_kp_q    <= 4'h0;
      r_seg     <= 16'h0000;
      r_leds    <= 8'h00;
      r_bus_err <= 1'b0;
    end else begin
      r_sel     <= w_sel;
      r_sel_vld <= 1'b1;
      if (w_kp_hit) r_kp_q <= kp_data;
      if (cpu_we && (w_sel == SEL_SEG)) r_seg  <= cpu_wdata;
      if (cpu_we && (w_sel == SEL_LED)) r_leds <= cpu_wdata[7:0];
      r_bus_err <= w_err_set || (r_bus_err && !w_err_clr);
    end
  end

  // Register sources are read live in the data cycle; they only change at
  // the edge that ends that cycle, so a read sees the value before any write
  // issued alongside it.
  always_comb begin
    w_rdata = 16'h0000;
    if (r_sel_vld) begin
      case (r_sel)
        SEL_RAM:          w_rdata = mem_rdata;
        SEL_KPD, SEL_KPS: w_rdata = {12'h000, r_kp_q};
        SEL_SEG:          w_rdata = r_seg;
        SEL_LED:          w_rdata = {8'h00, r_leds};
        SEL_ERR:          w_rdata = {15'h0000, r_bus_err};
        default:          w_rdata = UNMAPPED_VAL;
      endcase
    end
  end

  assign cpu_rdata = w_rdata;
  assign seg_data  = r_seg;
  assign leds      = r_leds;
  assign bus_err   = r_bus_err;

  kp_ack_fsm u_kp_ack_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_kp_data_hit (w_sel == SEL_KPD),
    .i_cpu_we      (cpu_we),
    .o_kp_ack      (kp_ack)
  );

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Directed bench for mmio_bus_controller. Reads push their hand-computed
// expected data into a scoreboard queue; a monitor pops and compares when the
// read data is due, one cycle after the address.
module tb_mmio_bus_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  kp_data;
  logic        kp_sel_status;
  logic        kp_ack;
  logic [15:0] seg_data;
  logic [7:0]  leds;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int ack_base;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  logic rd_issue;
  logic rd_pend;

  // Keypad model: key 7 pending, status reads 3.
  assign kp_data = kp_sel_status ? 4'h3 : 4'h7;

  // Synchronous RAM model.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  mmio_bus_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_rdata     (cpu_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .kp_data       (kp_data),
    .kp_sel_status (kp_sel_status),
    .kp_ack        (kp_ack),
    .seg_data      (seg_data),
    .leds          (leds),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-data due marker: set on the edge that ends a checked read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_issue;
  end

  // Monitor: compare read data mid data-cycle.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_empty: got %h expected none", cpu_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, cpu_rdata, e.exp);
      end
    end
    if (rst_n && kp_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic set_bus(input logic [15:0] a, input logic we,
                         input logic [15:0] d);
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wdata = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic rd_open(input logic [15:0] a, input logic [15:0] exp,
                         input string name);
    exp_t e;
    set_bus(a, 1'b0, 16'h0000);
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    rd_issue = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                    input string name);
    rd_open(a, exp, name);
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    set_bus(a, 1'b1, d);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    cpu_we    = 1'b0;
    rd_issue  = 1'b0;

    // Reset state.
    #3;
    check("rst_rdata",   cpu_rdata, 16'h0000);
    check("rst_seg",     seg_data,  16'h0000);
    check("rst_leds",    {8'h00, leds}, 16'h0000);
    check("rst_bus_err", {15'h0, bus_err}, 16'h0000);
    check("rst_kp_ack",  {15'h0, kp_ack},  16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Register reads after reset.
    rd(16'hD002, 16'h0000, "rd_seg_rst");
    rd(16'hD003, 16'h0000, "rd_led_rst");
    rd(16'hD004, 16'h0000, "rd_err_rst");
    set_bus(16'h0010, 1'b0, 16'h0000);
    step();
    check("leds_rst", {8'h00, leds}, 16'h0000);
    check("no_ack_yet", ack_cnt[15:0], 16'h0000);

    // RAM write then read, both windows and their boundaries.
    set_bus(16'h0010, 1'b1, 16'h1234);
    check("mem_we_wr", {15'h0, mem_we}, 16'h0001);
    step();
    rd_open(16'h0010, 16'h1234, "rd_ram_0010");
    check("mem_we_rd", {15'h0, mem_we}, 16'h0000);
    step();
    set_bus(16'hCFFF, 1'b1, 16'h0C0F);
    check("mem_we_cfff", {15'h0, mem_we}, 16'h0001);
    step();
    set_bus(16'hF000, 1'b1, 16'hF00F);
    check("mem_we_f000", {15'h0, mem_we}, 16'h0001);
    step();
    wr(16'hFFFF, 16'hA55A);
    rd(16'hCFFF, 16'h0C0F, "rd_ram_cfff");
    rd(16'hF000, 16'hF00F, "rd_ram_f000");
    rd(16'hFFFF, 16'hA55A, "rd_ram_ffff");
    check("no_err_ram", {15'h0, bus_err}, 16'h0000);

    // SEG / LED registers.
    wr(16'hD002, 16'hBEEF);
    wr(16'hD003, 16'h01A5);
    check("seg_beef", seg_data, 16'hBEEF);
    check("leds_a5",  {8'h00, leds}, 16'h00A5);
    rd(16'hD002, 16'hBEEF, "rd_seg");
    rd(16'hD003, 16'h00A5, "rd_led");

    // Keypad: held read acks once; status read never acks.
    ack_base = ack_cnt;
    rd(16'hD000, 16'h0007, "rd_kpd_1");
    rd(16'hD000, 16'h0007, "rd_kpd_2");
    rd(16'hD000, 16'h0007, "rd_kpd_3");
    check("ack_once", 16'(ack_cnt - ack_base), 16'h0001);
    rd_open(16'hD001, 16'h0003, "rd_kps");
    check("kp_sel_status", {15'h0, kp_sel_status}, 16'h0001);
    step();
    rd(16'hD000, 16'h0007, "rd_kpd_again");
    rd(16'h0010, 16'h1234, "rd_ram_after_kp");
    check("ack_twice", 16'(ack_cnt - ack_base), 16'h0002);

    // Bus error: set, sticky, read, clear, illegal writes.
    rd(16'hE000, 16'hF345, "rd_unmapped");
    check("err_set", {15'h0, bus_err}, 16'h0001);
    rd(16'h0010, 16'h1234, "rd_ram_sticky");
    check("err_sticky", {15'h0, bus_err}, 16'h0001);
    rd(16'hD004, 16'h0001, "rd_err_set");
    wr(16'hD004, 16'h0000);
    check("err_clr", {15'h0, bus_err}, 16'h0000);
    rd(16'hD004, 16'h0000, "rd_err_clr");
    set_bus(16'hD000, 1'b1, 16'h0009);
    check("mem_we_kpd_wr", {15'h0, mem_we}, 16'h0000);
    step();
    check("err_kpd_wr", {15'h0, bus_err}, 16'h0001);
    check("no_ack_on_wr", {15'h0, kp_ack}, 16'h0000);
    wr(16'hD004, 16'h0000);
    set_bus(16'hD005, 1'b1, 16'h0001);
    check("mem_we_d005", {15'h0, mem_we}, 16'h0000);
    step();
    check("err_d005", {15'h0, bus_err}, 16'h0001);

    // Reset while kp_ack is high.
    wr(16'hD002, 16'h55AA);
    set_bus(16'hE000, 1'b0, 16'h0000);
    step();
    set_bus(16'hD000, 1'b0, 16'h0000);
    step();
    check("pre_rst_ack", {15'h0, kp_ack}, 16'h0001);
    check("pre_rst_seg", seg_data, 16'h55AA);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack",   {15'h0, kp_ack},  16'h0000);
    check("mid_rst_seg",   seg_data,         16'h0000);
    check("mid_rst_err",   {15'h0, bus_err}, 16'h0000);
    check("mid_rst_rdata", cpu_rdata,        16'h0000);
    set_bus(16'h0010, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    rd(16'hD002, 16'h0000, "rd_seg_after_rst");
    ack_base = ack_cnt;
    rd(16'hD000, 16'h0007, "rd_kpd_after_rst");
    rd(16'h0010, 16'h1234, "rd_ram_after_rst");
    check("ack_after_rst", 16'(ack_cnt - ack_base), 16'h0001);

    step();
    step();
    check("sb_drained", 16'(sb_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bus_controller.md
Name: mmio_bus_controller

Overview:
Address decoder and sequencer between the bird CPU bus and the system's memory-mapped resources: RAM (two windows), keypad, seven-segment register, LED register and an error register. It generates the RAM write strobe and the registered read-data mux. It drives the keypad acknowledge handshake so that each CPU read of the key data register consumes exactly one key. It also records accesses to unmapped addresses.

Parameters:
RAM1_BASE, 16'h0000, first address of RAM window 1
RAM1_END, 16'hCFFF, last address of RAM window 1
KP_DATA_ADDR, 16'hD000, keypad data register (read consumes key)
KP_STAT_ADDR, 16'hD001, keypad status register (read-only, non-consuming)
SEG_ADDR, 16'hD002, seven-segment data register (R/W)
LED_ADDR, 16'hD003, LED register (R/W, low 8 bits)
ERR_ADDR, 16'hD004, bus-error register (read bit0; any write clears)
RAM2_BASE, 16'hF000, first address of RAM window 2
RAM2_END, 16'hFFFF, last address of RAM window 2
UNMAPPED_VAL, 16'hF345, read value for unmapped addresses

Ports:
clk  input  1  system clock; all state on posedge
rst_n  input  1  asynchronous, active-low reset
cpu_addr  input  16  CPU address, valid in the cycle of the access
cpu_wdata  input  16  CPU write data
cpu_we  input  1  CPU write strobe
cpu_rdata  output  16  read data; valid one cycle after the address
mem_addr  output  16  RAM address (= cpu_addr)
mem_wdata  output  16  RAM write data (= cpu_wdata)
mem_we  output  1  RAM write enable, combinational
mem_rdata  input  16  synchronous RAM output (registered inside RAM)
kp_data  input  4  keypad key code or status, as selected by kp_sel_status
kp_sel_status  output  1  1 = keypad drives status, 0 = key data
kp_ack  output  1  one-cycle key-consume pulse
seg_data  output  16  seven-segment value
leds  output  8  LED value
bus_err  output  1  sticky unmapped-access flag

Behaviour:
- Reset (async assert, sync release): seg_data=0, leds=0, bus_err=0, kp_ack=0, cpu_rdata=0, read-select register=NONE, keypad FSM=KP_IDLE.
- Decode is combinational on cpu_addr. Windows and registers are inclusive. Any other address is unmapped.
- mem_we = cpu_we & (address in RAM1 or RAM2). No RAM write occurs elsewhere.
- SEG/LED writes: on posedge with cpu_we at SEG_ADDR or LED_ADDR, the register loads cpu_wdata (LED loads [7:0]). The value is visible the next cycle.
- ERR write: any write to ERR_ADDR clears bus_err.
- bus_err is set on posedge for:
  - any access to an unmapped address;
  - a write to KP_DATA_ADDR or KP_STAT_ADDR.
- Read path, one-cycle latency:
  - Register region select sel_q and a kp_q snapshot every cycle.
  - cpu_rdata = mux(sel_q):
    - RAM: mem_rdata
    - KP data/status: {12'b0, kp_q}
    - SEG: seg_data
    - LED: {8'b0, leds}
    - ERR: {15'b0, bus_err}
    - unmapped: UNMAPPED_VAL
  - Register reads return the value before any same-cycle write.
- kp_sel_status = (cpu_addr == KP_STAT_ADDR), combinational. kp_q captures kp_data each cycle that KP_DATA_ADDR or KP_STAT_ADDR is addressed.
- Keypad FSM:
  - KP_IDLE: a read (cpu_we=0) at KP_DATA_ADDR sets kp_ack=1 for the next cycle only and moves to KP_ACKED.
  - KP_ACKED: kp_ack=0. Stay while cpu_addr == KP_DATA_ADDR. Any other address returns to KP_IDLE.
  - A held or repeated-cycle read therefore acks exactly once. Back-to-back reads need an intervening different address.
- Reads of KP_STAT_ADDR never ack.
- Reset mid-ack: kp_ack drops immediately and the FSM returns to KP_IDLE.

Decomposition:
- Shared package mmio_pkg holds the address localparams, UNMAPPED_VAL and the region-select enum (RAM, KPD, KPS, SEG, LED, ERR, NONE).
- One sub-module, kp_ack_fsm: keypad acknowledge one-shot with the KP_IDLE/KP_ACKED states.

Test Plan:
- Reset, then read 0xD002, 0xD003, 0xD004 -> cpu_rdata 0x0000, 0x0000, 0x0000; leds=0; kp_ack never high.
- Write 0x1234 to 0x0010, then read 0x0010 -> mem_we=1 for one cycle; cpu_rdata=0x1234 one cycle after the read address.
- Write 0xBEEF to 0xD002 and 0x01A5 to 0xD003 -> seg_data=0xBEEF, leds=0xA5; readback gives 0xBEEF and 0x00A5.
- Hold a read at 0xD000 for 3 cycles with kp_data=4'h7 -> kp_ack high exactly 1 cycle; cpu_rdata=0x0007. Move to 0xD001, then back to 0xD000 -> a second single ack; the 0xD001 read gives kp_sel_status=1 and no ack.
- Read 0xE000 -> cpu_rdata=0xF345, bus_err=1 and sticky. Read 0xD004 -> 0x0001. Write 0xD004 -> bus_err=0. Write 0xD000 -> bus_err=1 and mem_we=0.
- Assert rst_n=0 during kp_ack high and after a SEG write -> kp_ack, seg_data and bus_err go to 0 asynchronously.
